// File: rtl/seg7_scan_if.sv
// Signal bundle between a BCD source and the seven-segment scan driver.
//
// Handshake: load is a single-cycle strobe with no back-pressure. On any
// clock edge where load=1, din/dp_in are captured; the driver is always
// ready, so there is no ready signal and a later strobe simply replaces an
// earlier one that has not yet reached the display.
interface seg7_scan_if;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic        enable;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  scan_idx;

    modport master (
        output load, din, dp_in, enable,
        input  seg, dp, an, scan_idx
    );

    modport slave (
        input  load, din, dp_in, enable,
        output seg, dp, an, scan_idx
    );
endinterface

// File: rtl/seg7_scan_display.sv
// Four-digit time-multiplexed common-anode seven-segment driver.
// A pending buffer collects loads; it is copied into the display buffer
// only at a frame boundary (tick on the last digit), so a refresh frame
// never mixes two values. All outputs are registered one cycle behind idx.
module seg7_scan_display #(
    parameter int REFRESH_COUNT = 100000,
    parameter int CW            = 17,
    parameter bit LZ_BLANK      = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    seg7_scan_if.slave bus
);

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_COUNT - 1);

    // Buffers hold {dp[3:0], bcd[15:0]}.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [19:0]   pend_buf_q, pend_buf_d;
    logic          pend_vld_q, pend_vld_d;
    logic [19:0]   disp_buf_q, disp_buf_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic [1:0]    scan_idx_q, scan_idx_d;

    logic          tick;
    logic          frame_end;
    logic [19:0]   load_word;
    logic [3:0]    cur_nib;
    logic          cur_dp;
    logic [3:0]    lead;
    logic          digit_blank;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;  // non-BCD nibble shows a dash
        endcase
        return s;
    endfunction

    // Refresh counter, digit index and double-buffer update.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pend_buf_d = pend_buf_q;
        pend_vld_d = pend_vld_q;
        disp_buf_d = disp_buf_q;

        tick      = (cnt_q == CNT_LAST);
        frame_end = tick && (idx_q == 2'd3);
        load_word = {bus.dp_in, bus.din};

        if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (bus.load) begin
            pend_buf_d = load_word;
            pend_vld_d = 1'b1;
        end

        // A load on the boundary edge bypasses the pending buffer so it
        // shows in the frame starting at that edge.
        if (frame_end) begin
            pend_vld_d = 1'b0;
            if (bus.load) begin
                disp_buf_d = load_word;
            end else if (pend_vld_q) begin
                disp_buf_d = pend_buf_q;
            end
        end
    end

    // Digit decode with leading-zero blanking; a lit dp on a higher digit
    // makes every lower zero significant.
    always_comb begin
        cur_nib = disp_buf_q[{idx_q, 2'b00} +: 4];
        cur_dp  = disp_buf_q[5'd16 + {3'd0, idx_q}];

        lead[3] = (disp_buf_q[15:12] == 4'd0) && !disp_buf_q[19];
        lead[2] = lead[3] && (disp_buf_q[11:8] == 4'd0) && !disp_buf_q[18];
        lead[1] = lead[2] && (disp_buf_q[7:4] == 4'd0) && !disp_buf_q[17];
        lead[0] = 1'b0;
        digit_blank = LZ_BLANK && lead[idx_q];

        scan_idx_d = idx_q;
        if (!bus.enable) begin
            an_d  = 4'b1111;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = digit_blank ? 7'h7F : seg_encode(cur_nib);
            dp_d  = ~cur_dp;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            pend_buf_q <= '0;
            pend_vld_q <= 1'b0;
            disp_buf_q <= '0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= 4'b1111;
            scan_idx_q <= 2'd0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_buf_q <= pend_buf_d;
            pend_vld_q <= pend_vld_d;
            disp_buf_q <= disp_buf_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
    assign bus.an       = an_q;
    assign bus.scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display with REFRESH_COUNT=4: a frame is 16 cycles.
// Reference: the value on display during frame f is the last load sampled
// before frame f begins; each output sample reflects the digit of the
// previous cycle.
module tb_seg7_scan_display;

    localparam int RC    = 4;
    localparam int FRAME = 4 * RC;

    logic clk = 1'b0;
    logic rst_n;
    seg7_scan_if bus ();

    seg7_scan_display #(.REFRESH_COUNT(RC), .CW(3), .LZ_BLANK(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic [19:0] val;
    } load_t;

    load_t      hist[$];
    int         k;          // cycles since reset release (counter position)
    int         pass_cnt = 0;
    int         total    = 0;
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F,
                                 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    endtask

    function automatic logic [19:0] shown(input int kk);
        int base = (kk / FRAME) * FRAME;
        logic [19:0] v = '0;
        foreach (hist[i]) if (hist[i].stamp < base) v = hist[i].val;
        return v;
    endfunction

    // One clock: drive inputs, model the edge, check the registered outputs.
    task automatic step(input logic ld, input logic [15:0] d,
                        input logic [3:0] dpi, input logic en);
        logic [19:0] v;
        int          idx, top, nib;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [3:0]  e_an;
        bus.load   = ld;
        bus.din    = d;
        bus.dp_in  = dpi;
        bus.enable = en;
        @(posedge clk);
        v   = shown(k);
        idx = (k / RC) % 4;
        top = 0;
        for (int j = 0; j < 4; j++)
            if (((v >> (4 * j)) & 20'hF) != 0 || v[16 + j]) top = j;
        nib = int'((v >> (4 * idx)) & 20'hF);
        if (!en) begin
            e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = 4'b1111;
            e_an[idx] = 1'b0;
            e_seg = (idx > top) ? 7'h7F : seg_tbl[nib];
            e_dp  = ~v[16 + idx];
        end
        if (ld) hist.push_back('{k, {dpi, d}});
        k++;
        #1;
        chk("an", {3'd0, bus.an}, {3'd0, e_an});
        chk("seg", bus.seg, e_seg);
        chk("dp", {6'd0, bus.dp}, {6'd0, e_dp});
        chk("scan_idx", {5'd0, bus.scan_idx}, 7'(idx));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b1);
    endtask

    task automatic load_now(input logic [15:0] d, input logic [3:0] dpi);
        step(1'b1, d, dpi, 1'b1);
    endtask

    // Advance with idle cycles until the next edge samples counter position ph.
    task automatic run_to(input int ph);
        for (int g = 0; g < FRAME && (k % FRAME) != ph; g++) idle(1);
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        bus.load  = 1'b1;
        bus.din   = 16'h9999;
        bus.dp_in = 4'hF;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            chk("rst_an", {3'd0, bus.an}, 7'h0F);
            chk("rst_seg", bus.seg, 7'h7F);
            chk("rst_dp", {6'd0, bus.dp}, 7'd1);
            chk("rst_idx", {5'd0, bus.scan_idx}, 7'd0);
        end
        rst_n    = 1'b1;
        bus.load = 1'b0;
        hist.delete();
        k = 0;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int j = 0; j < 4; j++)
            w[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return w;
    endfunction

    initial begin
        rst_n      = 1'b0;
        bus.load   = 1'b0;
        bus.din    = '0;
        bus.dp_in  = '0;
        bus.enable = 1'b1;
        k          = 0;
        do_reset(2);

        // Reset mid-scan with a load still pending.
        idle(20);
        run_to(5);
        load_now(16'h8765, 4'b0010);
        idle(2);
        do_reset(3);
        idle(FRAME + 4);

        // Basic scan of 1234, loaded mid-frame.
        run_to(3);
        load_now(16'h1234, 4'h0);
        idle(2 * FRAME);

        // Leading-zero blanking and dp-forced significance.
        load_now(16'h0070, 4'h0);
        idle(2 * FRAME);
        load_now(16'h0000, 4'h0);
        idle(2 * FRAME);
        load_now(16'h0070, 4'b1000);
        idle(2 * FRAME);
        load_now(16'h00A5, 4'h0);
        idle(2 * FRAME);

        // Tear-free update: last pending load wins; boundary load is immediate.
        load_now(16'h1111, 4'h0);
        run_to(0);
        idle(4);
        load_now(16'h2222, 4'h0);
        run_to(8);
        load_now(16'h3333, 4'h0);
        idle(FRAME + 4);
        run_to(FRAME - 1);
        load_now(16'h4444, 4'h1);
        idle(FRAME);

        // Display blanking while the scan keeps running.
        idle(3);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
        idle(FRAME);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 7) == 0, rand_word(), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 $urandom_range(0, 9) != 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Four-digit, time-multiplexed, common-anode seven-segment display driver.
- Sits downstream of the debounced BCD counters and consumes their value.
- Latches a 16-bit packed-BCD word and scans it out one digit at a time on seg/dp/an.
- Uses double buffering, so an update never appears partway through a refresh frame.

Parameters:
- REFRESH_COUNT, 100000: clock cycles each digit stays lit (1 ms at 100 MHz). Must be at least 2.
- CW, 17: width of the refresh counter. Must satisfy 2^CW >= REFRESH_COUNT.
- LZ_BLANK, 1: 1 enables leading-zero blanking; 0 shows all four digits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- load  in  1  single-cycle strobe; captures din and dp_in
- din  in  16  packed BCD; [3:0] is digit0 (rightmost), [15:12] is digit3
- dp_in  in  4  decimal point request per digit, 1 = on
- enable  in  1  0 blanks the display; scanning continues
- seg  out  7  segment drive, active-low, order {g,f,e,d,c,b,a}
- dp  out  1  decimal point drive, active-low
- an  out  4  digit enable, active-low, one-hot-low
- scan_idx  out  2  index of the digit currently being driven

Behaviour:
- Reset:
  - Applied when rst_n=0 is sampled at a clk edge.
  - Clears refresh counter, idx, pending buffer, pending flag and display buffer.
  - Outputs after reset: an=4'b1111, seg=7'h7F, dp=1, scan_idx=0.
  - A pending load in flight when reset is applied is discarded.
- Refresh counter:
  - Counts 0..REFRESH_COUNT-1, then wraps to 0.
  - tick is asserted on the cycle the counter equals REFRESH_COUNT-1.
  - On tick, idx advances mod 4.
- Frame boundary: a tick while idx==3. At that edge idx becomes 0 and the buffer swap occurs.
- Loading and buffer swap:
  - load=1 writes {dp_in,din} into the pending buffer and sets the pending flag.
  - A later load before the swap overwrites the pending buffer; the last value wins.
  - At a frame boundary with pending=1, the pending buffer is copied into the display buffer and pending is cleared.
  - If load=1 in the same cycle as the frame boundary, the display buffer takes din/dp_in directly and pending is cleared.
  - With no load, the display buffer holds its value indefinitely.
- Outputs:
  - All outputs are registered from the current idx and display buffer, one cycle behind idx (fixed 1-cycle latency).
  - an: bit idx = 0, all other bits = 1.
  - scan_idx is the registered copy of idx.
  - dp = ~dp bit of the current digit.
- Segment encoding (hex values):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Nibbles A-F display a dash: 3F.
  - Blanked digit: 7F.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k (k = 3..1) is blanked when its nibble and every higher nibble are 0 and its dp bit is 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its an bit low; the segments are simply off.
- enable=0: an=4'b1111, seg=7F, dp=1 from the next edge. The counter, idx and buffers keep running.
- Only idx, the counter and the buffers are state; there are no undefined states.

Test Plan (REFRESH_COUNT=4, CW=3):
1. rst_n=0 for 3 cycles mid-scan, with a load pending:
   - Outputs are an=1111, seg=7F, dp=1, scan_idx=0.
   - After release, the display shows blanked 000 followed by digit0=40.
   - The pending value never appears.
2. load din=16'h1234, enable=1:
   - Nothing changes until the next frame boundary.
   - Then an=1110/seg=19, 1101/30, 1011/24, 0111/79.
   - Each digit is held for exactly 4 cycles.
   - an changes 1 cycle after each tick.
3. LZ_BLANK=1, din=16'h0070:
   - Digits 3 and 2 show 7F; digit1 shows 78; digit0 shows 40.
   - With din=16'h0000, only digit0 shows 40.
   - With din=16'h0070 and dp_in=4'b1000, digit3 shows 40 with dp=0, and digit2 shows 40 (no longer leading).
4. din=16'h00A5:
   - Digit1 shows 3F and digit0 shows 12.
   - Digits 3 and 2 are blanked, since they are leading zeros.
5. Tear-free update:
   - With 16'h1111 displayed, load 16'h2222 while scan_idx=1, then load 16'h3333 while scan_idx=2.
   - The current frame stays all 79.
   - The next frame is all 30; 16'h2222 is never shown.
   - A load coinciding with the frame boundary appears in the frame that starts at that edge.
6. Drop enable to 0 for 10 cycles:
   - an=1111 and seg=7F while low.
   - After re-enable, scanning resumes at the idx implied by the free-running counter, with no reset.
